// File: rtl/dense_backward_weight_reader.sv
// dense_backward_weight_reader
//   Sweeps the dense weight memory row by row, hidden index outer and chunk
//   index inner, and delivers each row to the backward q consumer. Row
//   (cnt_h, cnt_c) lives at BASE_ADDR + cnt_h*NCH + cnt_c, modulo 2^ADDR_W.
//
//   Optional feature macro: DENSE_RDATA_REG_EN
//     undefined : rdata = mem_rdata, run_q = run, done straight from the FSM
//     defined   : rdata, run_q and done each pass through one register
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   run        in   level request: high sweeps, low aborts and clears
//   mem_en     out  memory read enable
//   mem_addr   out  memory read row address (ADDR_W)
//   mem_rdata  in   memory read data, one cycle after mem_en/mem_addr
//   rdata      out  weight row to the consumer
//   run_q      out  run for the consumer, aligned with rdata
//   done       out  last row issued, held while run stays high
//
// States
//   IDLE | counters cleared; a high run issues row (0,0) this same cycle
//   READ | one row issued per cycle
//   HOLD | sweep complete; counters and address frozen, done high

`ifndef N_LEN
`define N_LEN 16
`endif
`ifndef CHAR_NUM
`define CHAR_NUM 192
`endif
`ifndef HID_DIM
`define HID_DIM 24
`endif

module dense_backward_weight_reader #(
  parameter int DENSE_DATA_N = 8,
  parameter int ADDR_W       = 10,
  parameter int BASE_ADDR    = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             run,
  output logic                             mem_en,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic [DENSE_DATA_N*`N_LEN-1:0]   mem_rdata,
  output logic [DENSE_DATA_N*`N_LEN-1:0]   rdata,
  output logic                             run_q,
  output logic                             done
);

  localparam int NCH = `CHAR_NUM / DENSE_DATA_N;
  localparam int DW  = DENSE_DATA_N * `N_LEN;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] NCH_A  = ADDR_W'(NCH);
  localparam logic [4:0]        C_LAST = 5'(NCH - 1);
  localparam logic [4:0]        H_LAST = 5'(`HID_DIM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_c_q, cnt_c_d;
  logic [4:0] cnt_h_q, cnt_h_d;
  logic       issue;
  logic       last_row;
  logic       done_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_c_q <= 5'd0;
      cnt_h_q <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_c_q <= cnt_c_d;
      cnt_h_q <= cnt_h_d;
    end
  end

  // The last row is issued without advancing the counters, so HOLD keeps
  // presenting the final address.
  always_comb begin
    state_d  = state_q;
    cnt_c_d  = cnt_c_q;
    cnt_h_d  = cnt_h_q;
    issue    = 1'b0;
    last_row = (cnt_h_q == H_LAST) && (cnt_c_q == C_LAST);
    if (!run) begin
      state_d = IDLE;
      cnt_c_d = 5'd0;
      cnt_h_d = 5'd0;
    end else begin
      case (state_q)
        IDLE, READ: begin
          issue = 1'b1;
          if (last_row) begin
            state_d = HOLD;
          end else begin
            state_d = READ;
            if (cnt_c_q == C_LAST) begin
              cnt_c_d = 5'd0;
              cnt_h_d = cnt_h_q + 5'd1;
            end else begin
              cnt_c_d = cnt_c_q + 5'd1;
            end
          end
        end
        HOLD:    state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  // IDLE issues combinationally from run, so reset must mask the enable.
  assign mem_en   = issue & rst_n;
  assign mem_addr = BASE_A + ADDR_W'(cnt_h_q) * NCH_A + ADDR_W'(cnt_c_q);
  assign done_raw = (state_q == HOLD);

`ifdef DENSE_RDATA_REG_EN
  logic [DW-1:0] rdata_q;
  logic          run_d1_q;
  logic          done_d1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q   <= '0;
      run_d1_q  <= 1'b0;
      done_d1_q <= 1'b0;
    end else begin
      rdata_q   <= mem_rdata;
      run_d1_q  <= run;
      done_d1_q <= done_raw;
    end
  end

  assign rdata = rdata_q;
  assign run_q = run_d1_q;
  assign done  = done_d1_q;
`else
  assign rdata = mem_rdata[DW-1:0];
  assign run_q = run & rst_n;
  assign done  = done_raw;
`endif

endmodule

// File: doc/dense_backward_weight_reader.md
DENSE_BACKWARD_WEIGHT_READER -- requirements
Module: dense_backward_weight_reader

Interface
REQ-001 SHALL have parameter DENSE_DATA_N, default 8: weight words per memory row, matching the consumer chunk size.
REQ-002 SHALL have parameter ADDR_W, default 10: weight memory address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0: row address of weight element (hid 0, chunk 0).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port run, input, 1: level request; high = sweep the weights, low = abort and clear.
REQ-007 SHALL have port mem_en, output, 1: memory read enable.
REQ-008 SHALL have port mem_addr, output, ADDR_W: memory read row address.
REQ-009 SHALL have port mem_rdata, input, DENSE_DATA_N*`N_LEN: memory read data, returned exactly 1 cycle after the mem_en/mem_addr cycle.
REQ-010 SHALL have port rdata, output, DENSE_DATA_N*`N_LEN: weight row delivered to the backward q consumer.
REQ-011 SHALL have port run_q, output, 1: run for the consumer, aligned so its chunk index matches rdata.
REQ-012 SHALL have port done, output, 1: last row issued, held while run stays high.

Function
REQ-013 SHALL define NCH = `CHAR_NUM/DENSE_DATA_N (24 in the bench configuration) and sweep HID_DIM x NCH rows.
REQ-014 SHALL hold counters cnt_c (chunk, 0..NCH-1) and cnt_h (hidden, 0..`HID_DIM-1), each 5 bits wide.
REQ-015 SHALL implement FSM IDLE -> READ -> HOLD; IDLE->READ on run; READ->HOLD after issuing row (HID_DIM-1, NCH-1); any state -> IDLE on run low.
REQ-016 In READ, every cycle SHALL assert mem_en with mem_addr = BASE_ADDR + cnt_h*NCH + cnt_c (mod 2^ADDR_W); cnt_c increments, wraps to 0 at NCH-1 and cnt_h increments on that wrap.
REQ-017 The first read SHALL be issued in the same cycle run is first sampled high (combinational from IDLE counters = 0), i.e. the row (0,0) address is on mem_addr in that cycle.
REQ-018 In HOLD, mem_en SHALL be 0; counters, mem_addr and done=1 SHALL be frozen until run falls.
REQ-019 rdata SHALL equal mem_rdata combinationally (latency 1 from address) without the REQ-029 macro.
REQ-020 run_q SHALL equal run combinationally without the macro, so consumer chunk index t+1 pairs with row t.
REQ-021 done SHALL assert in the cycle after the last row is issued and stay high until run falls.
REQ-022 run low for one cycle mid-sweep SHALL clear counters, FSM->IDLE, mem_en=0, done=0 next edge; re-raising run restarts at row (0,0).
REQ-023 mem_en SHALL never be high in IDLE or HOLD; no row issued twice per sweep; exactly HID_DIM*NCH reads per sweep.

Reset
REQ-024 On rst_n low, FSM SHALL be IDLE and cnt_c, cnt_h SHALL be 0, asynchronously.
REQ-025 During reset: mem_en=0, mem_addr=BASE_ADDR, done=0, run_q=0, rdata=0 (registered variant) or mem_rdata pass-through.
REQ-026 Reset mid-sweep SHALL abandon the sweep; after release with run high the sweep restarts at row (0,0).
REQ-027 All pipeline/delay registers SHALL reset to 0.

Configuration
REQ-028 Macro DENSE_RDATA_REG_EN SHALL select the registered-output variant.
REQ-029 Defined: rdata registered from mem_rdata (2-cycle address-to-rdata latency); run_q = run delayed 1 cycle (reset 0); done delayed 1 cycle accordingly.
REQ-030 Undefined: REQ-019/REQ-020 combinational behaviour, no extra registers.

Verification
REQ-031 Reset then run high with CHAR_NUM=192, HID_DIM=24, BASE_ADDR=0 -> mem_addr 0,1,...,575 on consecutive cycles, then mem_en=0, done=1.
REQ-032 BASE_ADDR=100, model memory returns address as data -> rdata equals 100+k exactly 1 cycle (2 with DENSE_RDATA_REG_EN) after issue k; run_q aligned.
REQ-033 run dropped at cycle 30 for one cycle, then raised -> mem_en=0 and done=0 in the low cycle; next addresses restart 0,1,2.
REQ-034 rst_n pulsed low at row 300 -> outputs at reset values immediately; after release, sweep restarts at address 0.
REQ-035 Wrap check: BASE_ADDR=1000, ADDR_W=10 -> mem_addr wraps 1023 -> 0 at row 23.
REQ-036 Connect to dense_backward_q_block with all-ones d and unit weights -> consumer valid rises and every q element equals NCH-scaled expected value.
